// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge handshake between the MEM stage (master)
// and the data memory (slave).
interface mem_wb_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register: runs one data-memory access at a time
// and stalls upstream until it completes. Define MEMWB_TIMEOUT_EN for the access timeout.
module mem_wb_stage #(
  parameter int TIMEOUT = 15,
  parameter int TCW     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  em_alu,
  input  logic [31:0]  em_wdata,
  input  logic [31:0]  em_shifter,
  input  logic [63:0]  em_multi,
  input  logic [4:0]   em_wn,
  input  logic         em_regwrite,
  input  logic         em_memtoreg,
  input  logic         em_memread,
  input  logic         em_memwrite,
  input  logic         em_shiftctl,
  mem_wb_stage_if.master dm,
  output logic         en_reg,
  output logic         wb_regwrite,
  output logic         wb_memtoreg,
  output logic [31:0]  wb_rdata,
  output logic [31:0]  wb_aluout,
  output logic [63:0]  wb_multi,
  output logic [4:0]   wb_wn,
  output logic         mem_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q;
  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [31:0] dm_wdata_q;
  logic        wb_regwrite_q;
  logic        wb_memtoreg_q;
  logic [31:0] wb_rdata_q;
  logic [31:0] wb_aluout_q;
  logic [63:0] wb_multi_q;
  logic [4:0]  wb_wn_q;

  logic        mop;
  logic        tmo;
  logic        stall;
  logic [31:0] aluout_d;

  assign mop      = em_memread | em_memwrite;
  assign aluout_d = em_shiftctl ? em_shifter : em_alu;

`ifdef MEMWB_TIMEOUT_EN
  logic [TCW-1:0] cnt_q;
  logic           mem_err_q;
  // An ack in the final allowed cycle takes priority over the timeout.
  assign tmo     = (state_q == BUSY) & ~dm.dm_ack & (cnt_q == TCW'(TIMEOUT - 1));
  assign mem_err = mem_err_q;
`else
  logic [TCW-1:0] unused_timeout;
  assign unused_timeout = TCW'(TIMEOUT);
  assign tmo            = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // Upstream stall: a new access costs the IDLE cycle, then every BUSY cycle until ack/timeout.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = mop;
      BUSY:    stall = ~(dm.dm_ack | tmo);
      default: stall = 1'b0;
    endcase
  end

  assign en_reg = ~stall;

  // Access FSM, memory request registers and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= 32'h0;
      dm_wdata_q    <= 32'h0;
      wb_regwrite_q <= 1'b0;
      wb_memtoreg_q <= 1'b0;
      wb_rdata_q    <= 32'h0;
      wb_aluout_q   <= 32'h0;
      wb_multi_q    <= 64'h0;
      wb_wn_q       <= 5'd0;
`ifdef MEMWB_TIMEOUT_EN
      cnt_q         <= {TCW{1'b0}};
      mem_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (mop) begin
            state_q       <= BUSY;
            dm_req_q      <= 1'b1;
            dm_we_q       <= em_memwrite;
            dm_addr_q     <= em_alu;
            dm_wdata_q    <= em_wdata;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
`ifdef MEMWB_TIMEOUT_EN
            cnt_q         <= {TCW{1'b0}};
`endif
          end else begin
            wb_regwrite_q <= em_regwrite;
            wb_memtoreg_q <= em_memtoreg;
            wb_rdata_q    <= 32'h0;
            wb_aluout_q   <= aluout_d;
            wb_multi_q    <= em_multi;
            wb_wn_q       <= em_wn;
          end
        end
        BUSY: begin
          if (dm.dm_ack) begin
            state_q       <= IDLE;
            dm_req_q      <= 1'b0;
            wb_regwrite_q <= em_regwrite;
            wb_memtoreg_q <= em_memtoreg;
            wb_rdata_q    <= dm_we_q ? 32'h0 : dm.dm_rdata;
            wb_aluout_q   <= aluout_d;
            wb_multi_q    <= em_multi;
            wb_wn_q       <= em_wn;
          end else if (tmo) begin
            state_q       <= IDLE;
            dm_req_q      <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
`ifdef MEMWB_TIMEOUT_EN
            mem_err_q     <= 1'b1;
`endif
          end else begin
            wb_regwrite_q <= 1'b0;
            wb_memtoreg_q <= 1'b0;
`ifdef MEMWB_TIMEOUT_EN
            cnt_q         <= cnt_q + TCW'(1);
`endif
          end
        end
        default: begin
          state_q  <= IDLE;
          dm_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dm.dm_req   = dm_req_q;
  assign dm.dm_we    = dm_we_q;
  assign dm.dm_addr  = dm_addr_q;
  assign dm.dm_wdata = dm_wdata_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_memtoreg = wb_memtoreg_q;
  assign wb_rdata    = wb_rdata_q;
  assign wb_aluout   = wb_aluout_q;
  assign wb_multi    = wb_multi_q;
  assign wb_wn       = wb_wn_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: ALU vector table plus
// hand-written load/store, back-to-back, reset-abort and timeout sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] em_alu, em_wdata, em_shifter;
  logic [63:0] em_multi;
  logic [4:0]  em_wn;
  logic        em_regwrite, em_memtoreg, em_memread, em_memwrite, em_shiftctl;
  logic        en_reg, wb_regwrite, wb_memtoreg, mem_err;
  logic [31:0] wb_rdata, wb_aluout;
  logic [63:0] wb_multi;
  logic [4:0]  wb_wn;

  int n_pass = 0;
  int n_tot  = 0;

  mem_wb_stage_if dm_if ();

  mem_wb_stage #(.TIMEOUT(4), .TCW(4)) dut (
    .clk(clk), .rst(rst),
    .em_alu(em_alu), .em_wdata(em_wdata), .em_shifter(em_shifter), .em_multi(em_multi),
    .em_wn(em_wn), .em_regwrite(em_regwrite), .em_memtoreg(em_memtoreg),
    .em_memread(em_memread), .em_memwrite(em_memwrite), .em_shiftctl(em_shiftctl),
    .dm(dm_if), .en_reg(en_reg),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rdata(wb_rdata),
    .wb_aluout(wb_aluout), .wb_multi(wb_multi), .wb_wn(wb_wn), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] shifter;
    logic [63:0] multi;
    logic [4:0]  wn;
    logic        rw;
    logic        m2r;
    logic        sc;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    em_alu = 32'h0; em_wdata = 32'h0; em_shifter = 32'h0; em_multi = 64'h0;
    em_wn = 5'd0; em_regwrite = 1'b0; em_memtoreg = 1'b0;
    em_memread = 1'b0; em_memwrite = 1'b0; em_shiftctl = 1'b0;
  endtask

  // One load/store; ack in request cycle ack_at (cycle 0 is the IDLE stall cycle).
  task automatic run_mem(input bit st, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_at, input logic rw,
                         input logic m2r, input logic [4:0] wn, input logic [31:0] prev_alu);
    int lows = 0;
    em_alu = addr; em_wdata = wdata; em_shifter = 32'hFFFF_0000; em_multi = 64'h1;
    em_wn = wn; em_regwrite = rw; em_memtoreg = m2r;
    em_memread = ~st; em_memwrite = st; em_shiftctl = 1'b0;
    dm_if.dm_ack = 1'b0;
    for (int c = 0; c <= ack_at; c++) begin
      if (c == 0) begin
        chk("idle_req_low", dm_if.dm_req, 1'b0);
      end else begin
        chk("req_high", dm_if.dm_req, 1'b1);
        chk("req_addr", dm_if.dm_addr, addr);
        chk("req_we", dm_if.dm_we, st);
        chk("req_wdata", dm_if.dm_wdata, wdata);
        chk("bubble_rw", wb_regwrite, 1'b0);
        chk("bubble_hold_alu", wb_aluout, prev_alu);
      end
      dm_if.dm_ack   = (c == ack_at) ? 1'b1 : 1'b0;
      dm_if.dm_rdata = (c == ack_at) ? rdata : 32'h0BAD_0BAD;
      #3;
      if (!en_reg) lows++;
      tick();
    end
    dm_if.dm_ack = 1'b0;
    chk("stall_cycles", lows, ack_at);
    chk("done_req_low", dm_if.dm_req, 1'b0);
    chk("wb_rdata", wb_rdata, st ? 32'h0 : rdata);
    chk("wb_regwrite", wb_regwrite, rw);
    chk("wb_memtoreg", wb_memtoreg, m2r);
    chk("wb_wn", wb_wn, wn);
    chk("wb_aluout", wb_aluout, addr);
    drive_nop();
  endtask

  initial begin
    vecs[0] = '{alu: 32'h0000_1234, shifter: 32'h0000_0000, multi: 64'h0,
                wn: 5'd5,  rw: 1'b1, m2r: 1'b0, sc: 1'b0, exp_alu: 32'h0000_1234};
    vecs[1] = '{alu: 32'h1111_1111, shifter: 32'hA5A5_0000, multi: 64'h0123_4567_89AB_CDEF,
                wn: 5'd31, rw: 1'b1, m2r: 1'b0, sc: 1'b1, exp_alu: 32'hA5A5_0000};
    vecs[2] = '{alu: 32'hFFFF_FFFF, shifter: 32'h0000_0001, multi: 64'hFFFF_FFFF_0000_0001,
                wn: 5'd0,  rw: 1'b0, m2r: 1'b1, sc: 1'b0, exp_alu: 32'hFFFF_FFFF};
    vecs[3] = '{alu: 32'h0000_0080, shifter: 32'h8000_0000, multi: 64'h8000_0000_0000_0000,
                wn: 5'd17, rw: 1'b1, m2r: 1'b0, sc: 1'b1, exp_alu: 32'h8000_0000};

    drive_nop();
    dm_if.dm_ack = 1'b0;
    dm_if.dm_rdata = 32'h0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_req", dm_if.dm_req, 1'b0);
    chk("rst_we", dm_if.dm_we, 1'b0);
    chk("rst_addr", dm_if.dm_addr, 32'h0);
    chk("rst_wdata", dm_if.dm_wdata, 32'h0);
    chk("rst_wb_rw", wb_regwrite, 1'b0);
    chk("rst_wb_alu", wb_aluout, 32'h0);
    chk("rst_wb_multi", wb_multi, 64'h0);
    chk("rst_mem_err", mem_err, 1'b0);
    chk("rst_en_reg", en_reg, 1'b1);
    rst = 1'b0;

    // Non-memory instructions: one-cycle latency, never stall.
    for (int i = 0; i < 4; i++) begin
      em_alu = vecs[i].alu; em_shifter = vecs[i].shifter; em_multi = vecs[i].multi;
      em_wn = vecs[i].wn; em_regwrite = vecs[i].rw; em_memtoreg = vecs[i].m2r;
      em_shiftctl = vecs[i].sc; em_wdata = 32'h5555_5555;
      #3;
      chk("alu_en_reg", en_reg, 1'b1);
      tick();
      chk("alu_wb_aluout", wb_aluout, vecs[i].exp_alu);
      chk("alu_wb_wn", wb_wn, vecs[i].wn);
      chk("alu_wb_rw", wb_regwrite, vecs[i].rw);
      chk("alu_wb_m2r", wb_memtoreg, vecs[i].m2r);
      chk("alu_wb_multi", wb_multi, vecs[i].multi);
      chk("alu_wb_rdata", wb_rdata, 32'h0);
    end
    drive_nop();

    run_mem(1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b1, 5'd7, 32'h8000_0000);
    run_mem(1'b1, 32'h0000_0080, 32'hCAFE_0001, 32'h1234_5678, 1, 1'b0, 1'b0, 5'd0, 32'h0000_0040);
    run_mem(1'b0, 32'h0000_0060, 32'h0, 32'h0F0F_0F0F, 1, 1'b1, 1'b1, 5'd9, 32'h0000_0080);
    run_mem(1'b1, 32'h0000_0064, 32'h7777_0000, 32'h0, 1, 1'b0, 1'b0, 5'd0, 32'h0000_0060);

    // Reset during BUSY withdraws the request; a later stray ack is ignored.
    em_alu = 32'h0000_0100; em_memread = 1'b1; em_regwrite = 1'b1; em_wn = 5'd3;
    tick();
    chk("busy_req", dm_if.dm_req, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_nop();
    chk("abort_req", dm_if.dm_req, 1'b0);
    chk("abort_wb_rw", wb_regwrite, 1'b0);
    chk("abort_wb_alu", wb_aluout, 32'h0);
    chk("abort_wb_wn", wb_wn, 5'd0);
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h1234_5678;
    #3;
    chk("stray_ack_en", en_reg, 1'b1);
    tick();
    dm_if.dm_ack = 1'b0;
    chk("stray_ack_req", dm_if.dm_req, 1'b0);
    chk("stray_ack_rdata", wb_rdata, 32'h0);

`ifdef MEMWB_TIMEOUT_EN
    em_alu = 32'h0000_0200; em_memread = 1'b1; em_regwrite = 1'b1; em_memtoreg = 1'b1; em_wn = 5'd4;
    tick();
    for (int k = 1; k <= 4; k++) begin
      chk("tmo_req", dm_if.dm_req, 1'b1);
      #3;
      chk("tmo_en_reg", en_reg, (k == 4) ? 1'b1 : 1'b0);
      tick();
    end
    drive_nop();
    chk("tmo_req_drop", dm_if.dm_req, 1'b0);
    chk("tmo_mem_err", mem_err, 1'b1);
    chk("tmo_wb_rw", wb_regwrite, 1'b0);
    tick(); tick(); tick();
    chk("tmo_err_sticky", mem_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("tmo_err_cleared", mem_err, 1'b0);
`endif

    run_mem(1'b0, 32'h0000_0300, 32'h0, 32'h600D_F00D, 4, 1'b1, 1'b1, 5'd12, 32'h0);
    chk("ack4_mem_err", mem_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage and MEM/WB pipeline register for the pipelined MIPS core. It consumes the EX/MEM register outputs and drives the data-memory request/acknowledge handshake for loads and stores. It also generates the `en_reg` enable that freezes EX/MEM and earlier stages while an access is outstanding, and registers the results for write-back.

## Interface
- `TIMEOUT`, 15: maximum BUSY cycles without `dm_ack` before abort; only used with `MEMWB_TIMEOUT_EN`.
- `TCW`, 4: width of the timeout counter; `TIMEOUT` < 2^`TCW`.

- `clk` in 1: single clock, all state updates on posedge. One clock.
- `rst` in 1: reset, synchronous and active-high.
- `em_alu` in 32: EX/MEM ALU result, used as the byte address for memory operations.
- `em_wdata` in 32: EX/MEM store data.
- `em_shifter` in 32: EX/MEM shifter result.
- `em_multi` in 64: EX/MEM multiplier product.
- `em_wn` in 5: destination register number.
- `em_regwrite`, `em_memtoreg`, `em_memread`, `em_memwrite`, `em_shiftctl` in 1 each: EX/MEM control bits.
- `dm_req` out 1: memory request, registered.
- `dm_we` out 1: 1 = store, 0 = load.
- `dm_addr` out 32: request address.
- `dm_wdata` out 32: request store data.
- `dm_rdata` in 32: load data; valid only when `dm_ack` = 1.
- `dm_ack` in 1: memory completion. Ignored unless `dm_req` = 1.
- `en_reg` out 1: upstream pipeline enable; combinational, equal to ~stall.
- `wb_regwrite`, `wb_memtoreg` out 1: MEM/WB control bits.
- `wb_rdata` out 32: registered load data.
- `wb_aluout` out 32: registered `em_shiftctl ? em_shifter : em_alu`.
- `wb_multi` out 64: registered product.
- `wb_wn` out 5: registered destination register number.
- `mem_err` out 1: sticky timeout flag.

## Operation
- Memory op: `mop = em_memread | em_memwrite`. If both bits are set, the operation is treated as a store.
- FSM states are IDLE and BUSY. Reset state is IDLE.
- IDLE with `mop`=0:
  - stall = 0.
  - MEM/WB loads the EX/MEM fields; `wb_rdata` loads 0.
- IDLE with `mop`=1:
  - stall = 1.
  - On the next edge: go to BUSY; `dm_req`←1; `dm_we`←`em_memwrite`; `dm_addr`←`em_alu`; `dm_wdata`←`em_wdata`.
  - MEM/WB loads a bubble: `wb_regwrite`=0, `wb_memtoreg`=0, other fields unchanged.
- BUSY:
  - `dm_req`, `dm_we`, `dm_addr` and `dm_wdata` hold stable.
  - While `dm_ack`=0: stall = 1 and MEM/WB loads a bubble.
  - When `dm_ack`=1: stall = 0. On that edge MEM/WB loads the EX/MEM fields, `wb_rdata`←`dm_rdata` for loads or 0 for stores, `dm_req`←0, and the FSM returns to IDLE.
  - A store completes with `wb_regwrite` = `em_regwrite`, which is normally 0.
- EX/MEM is frozen while stall = 1, so its fields are stable throughout an access.
- `dm_ack` while `dm_req`=0 is ignored and has no state effect.
- Back-to-back memory ops: IDLE is re-entered after the ack, and the next op starts a new request with a one-cycle IDLE stall. There is no request pipelining.

## Timing
- Non-memory instruction: 1-cycle latency from EX/MEM to MEM/WB. No stall.
- Memory op with ack after N cycles of `dm_req` (N ≥ 1): `en_reg` is low for N cycles, including the IDLE cycle. The MEM/WB update happens on the edge ending the ack cycle.
- Minimum load/store cost is 1 stall cycle.
- `en_reg` is combinational from state, `mop` and `dm_ack`. It must settle within the same cycle.
- Reset values:
  - `dm_req`=0, `dm_we`=0, `dm_addr`=0, `dm_wdata`=0.
  - All `wb_*` outputs 0, `mem_err`=0.
  - State IDLE, timeout counter 0.
  - `en_reg`=1 only if the EX/MEM inputs hold no memory op; with EX/MEM also reset, this holds.
- Reset during BUSY aborts the access the next cycle: `dm_req` drops and no MEM/WB write occurs. The memory side must tolerate a withdrawn request.

## Configuration
- `MEMWB_TIMEOUT_EN` defined:
  - A `TCW`-bit counter clears on IDLE→BUSY and increments each BUSY cycle without `dm_ack`.
  - When it reaches `TIMEOUT` with `dm_ack`=0: stall = 0 that cycle; on the edge `dm_req`←0, the FSM goes to IDLE, MEM/WB loads a bubble, and `mem_err`←1.
  - `mem_err` stays set until `rst`.
  - An ack arriving in the same cycle as the timeout wins: normal completion, no error.
- `MEMWB_TIMEOUT_EN` undefined:
  - No counter; BUSY waits indefinitely for `dm_ack`.
  - `mem_err` is tied to 0.
  - The `TIMEOUT` and `TCW` parameters are unused.

## Test plan
- ALU op with `em_regwrite`=1, `em_alu`=0x1234, `em_wn`=5 → next edge `wb_aluout`=0x1234, `wb_wn`=5, `wb_regwrite`=1; `en_reg` stays 1.
- Load at 0x40, `dm_ack` in the 3rd `dm_req` cycle with `dm_rdata`=0xDEADBEEF → `en_reg` low for exactly 3 cycles, `dm_addr`=0x40 stable, `dm_we`=0; then `wb_rdata`=0xDEADBEEF, `wb_memtoreg`=1; bubble (`wb_regwrite`=0) during the stall.
- Store 0xCAFE0001 to 0x80, ack after the 1st request cycle → `dm_we`=1, `dm_wdata`=0xCAFE0001; 1 stall cycle; `wb_regwrite`=0.
- Load immediately followed by a store, 1-cycle acks → two separate requests with `dm_req` low for 1 cycle between them; 2 total stall cycles.
- `rst` asserted during BUSY → `dm_req`=0 and all `wb_*`=0 the next cycle; a stray `dm_ack` afterwards is ignored.
- With `MEMWB_TIMEOUT_EN`, `TIMEOUT`=4 and no ack → `dm_req` drops after 4 BUSY cycles, `mem_err`=1 and stays 1, `wb_regwrite`=0. A repeat run with the ack in the 4th cycle → normal completion, `mem_err`=0.
